// File: rtl/boot_sequencer.sv
// Boot/run controller: copies program and register images from a synchronous ROM,
// holds the core in reset, then runs it until halt or a cycle budget. Optional ZERO_FILL_EN.
module boot_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int PROG_LEN    = 19,
  parameter int REG_COUNT   = 32,
  parameter int HOLD_CYCLES = 2,
  parameter int RUN_CYCLES  = 127,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W:0]   src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              core_rst,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

`ifdef ZERO_FILL_EN
  localparam int MEM_DEPTH = 2**ADDR_W;
`endif
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_INST, S_LOAD_REG, S_HOLD, S_RUN, S_DONE
`ifdef ZERO_FILL_EN
    , S_FILL
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         idx_q, idx_d;
  logic [ADDR_W:0]     src_addr_q, src_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                reg_we_q, reg_we_d;
  logic [4:0]          reg_addr_q, reg_addr_d;
  logic                core_rst_q, core_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]    cnt_inc;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    src_addr_d    = src_addr_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    reg_we_d      = 1'b0;
    reg_addr_d    = reg_addr_q;
    core_rst_d    = 1'b1;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    cnt_inc       = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LOAD_INST;
          idx_d         = '0;
          src_addr_d    = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
        end
      end
      // idx counts cycles in the state; the write for word k lands in cycle k+1
      S_LOAD_INST: begin
        if (idx_q < PROG_LEN) begin
          idx_d      = idx_q + 32'd1;
          src_addr_d = (ADDR_W+1)'(idx_q + 32'd1);
          mem_we_d   = 1'b1;
          mem_addr_d = ADDR_W'(idx_q);
        end else begin
`ifdef ZERO_FILL_EN
          if (PROG_LEN < MEM_DEPTH) begin
            state_d    = S_FILL;
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_W'(PROG_LEN);
          end else begin
            state_d    = S_LOAD_REG;
            idx_d      = '0;
            src_addr_d = (ADDR_W+1)'(PROG_LEN);
          end
`else
          state_d    = S_LOAD_REG;
          idx_d      = '0;
          src_addr_d = (ADDR_W+1)'(PROG_LEN);
`endif
        end
      end
`ifdef ZERO_FILL_EN
      S_FILL: begin
        if (mem_addr_q != '1) begin
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end else begin
          state_d    = S_LOAD_REG;
          idx_d      = '0;
          src_addr_d = (ADDR_W+1)'(PROG_LEN);
        end
      end
`endif
      S_LOAD_REG: begin
        if (idx_q < REG_COUNT) begin
          idx_d      = idx_q + 32'd1;
          src_addr_d = (ADDR_W+1)'(PROG_LEN + idx_q + 32'd1);
          reg_we_d   = 1'b1;
          reg_addr_d = 5'(idx_q);
        end else begin
          state_d = S_HOLD;
          idx_d   = '0;
        end
      end
      S_HOLD: begin
        if (idx_q == HOLD_CYCLES - 1) begin
          state_d    = S_RUN;
          core_rst_d = 1'b0;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      S_RUN: begin
        core_rst_d    = 1'b0;
        cycle_count_d = cnt_inc;
        if (halt || cnt_inc >= RUN_LIMIT) begin
          state_d    = S_DONE;
          core_rst_d = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          timeout_d  = !halt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      src_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      reg_we_q      <= 1'b0;
      reg_addr_q    <= '0;
      core_rst_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      src_addr_q    <= src_addr_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      reg_we_q      <= reg_we_d;
      reg_addr_q    <= reg_addr_d;
      core_rst_q    <= core_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // ROM data arrives in the write cycle itself, so write data is steered by the registered enables
  assign mem_wdata   = (mem_we_q && state_q == S_LOAD_INST) ? src_data : '0;
  assign reg_wdata   = reg_we_q ? src_data : '0;
  assign src_addr    = src_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign core_rst    = core_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule
